// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifetch_queue_pkg;

    localparam int unsigned ADDR_SIZE  = 32;
    localparam int unsigned INSTR_SIZE = 32;
    localparam int unsigned XLEN       = 32;

    localparam logic [INSTR_SIZE-1:0] IFQ_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFQ_FETCH = 2'd0,
        IFQ_STALL = 2'd1,
        IFQ_DRAIN = 2'd2
    } ifq_state_e;

    typedef struct packed {
        logic [INSTR_SIZE-1:0] instr;
        logic [ADDR_SIZE-1:0]  pc;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Instruction/PC storage FIFO with wrapping pointers, synchronous clear
// and asynchronous reset.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  ifq_entry_t       wdata_i,
    output ifq_entry_t       rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    ifq_entry_t       mem_q [DEPTH];
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: credit-limited imem requests, response FIFO,
// redirect flush. Define IFQ_BYPASS_EN for a 0-cycle empty-FIFO bypass.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned          DEPTH           = 4,
    parameter int unsigned          MAX_OUTSTANDING = 2,
    parameter logic [ADDR_SIZE-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_i,
    input  logic [ADDR_SIZE-1:0]         redirect_pc_i,
    output logic                         imem_req_o,
    output logic [ADDR_SIZE-1:0]         imem_addr_o,
    input  logic                         imem_gnt_i,
    input  logic                         imem_rvalid_i,
    input  logic [INSTR_SIZE-1:0]        imem_rdata_i,
    output logic                         instr_valid_o,
    output logic [INSTR_SIZE-1:0]        instr_o,
    output logic [ADDR_SIZE-1:0]         pc_o,
    input  logic                         instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    ifq_state_e           state_q;
    logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_SIZE-1:0] resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0]     outst_q, outst_d;
    logic [OUT_W-1:0]     discard_q, discard_d;
    logic [CNT_W-1:0]     count, count_d;
    logic                 fifo_empty, fifo_push, fifo_pop;
    logic                 grant, accept;
    ifq_entry_t           head, wentry;

    function automatic logic has_credit(input logic [CNT_W-1:0] cnt,
                                        input logic [OUT_W-1:0] outst);
        return ((32'(cnt) + 32'(outst)) < DEPTH) && (32'(outst) < MAX_OUTSTANDING);
    endfunction

    assign imem_req_o  = !reset && (state_q == IFQ_FETCH) && has_credit(count, outst_q);
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o && imem_gnt_i;
    assign accept      = imem_rvalid_i && (discard_q == '0);
    assign wentry      = '{instr: imem_rdata_i, pc: resp_pc_q};

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass    = accept && fifo_empty && !redirect_i;
    assign fifo_push = accept && !redirect_i && !(bypass && instr_ready_i);
`else
    assign fifo_push = accept && !redirect_i;
`endif
    assign fifo_pop  = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        instr_valid_o = !fifo_empty;
        instr_o       = fifo_empty ? IFQ_NOP : head.instr;
        pc_o          = fifo_empty ? RESET_PC : head.pc;
`ifdef IFQ_BYPASS_EN
        if (bypass) begin
            instr_valid_o = 1'b1;
            instr_o       = imem_rdata_i;
            pc_o          = resp_pc_q;
        end
`endif
    end

    // Redirect wins over same-cycle grant/push/pop; every request already
    // granted (including this cycle's) still returns and must be discarded.
    always_comb begin
        outst_d = outst_q;
        if (grant)         outst_d = outst_d + 1'b1;
        if (imem_rvalid_i) outst_d = outst_d - 1'b1;

        discard_d = discard_q;
        if (redirect_i)                                  discard_d = outst_d;
        else if (imem_rvalid_i && (discard_q != '0))     discard_d = discard_q - 1'b1;

        count_d = count;
        if (redirect_i) begin
            count_d = '0;
        end else begin
            if (fifo_push)               count_d = count_d + 1'b1;
            if (fifo_pop && !fifo_empty) count_d = count_d - 1'b1;
        end

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
        end else begin
            if (grant)  fetch_pc_d = fetch_pc_q + ADDR_SIZE'(4);
            if (accept) resp_pc_d  = resp_pc_q + ADDR_SIZE'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IFQ_FETCH;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if (redirect_i) begin
                state_q <= (outst_d != '0) ? IFQ_DRAIN : IFQ_FETCH;
            end else begin
                case (state_q)
                    IFQ_DRAIN: if (discard_d == '0) state_q <= IFQ_FETCH;
                    default:   state_q <= has_credit(count_d, outst_d) ? IFQ_FETCH : IFQ_STALL;
                endcase
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (redirect_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (count),
        .empty_o (fifo_empty)
    );

    assign count_o = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed table, corner sequences and
// a randomized run against an epoch-tagged queue model of the fetch stream.
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
    logic [2:0]  count_o;

    ifetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    typedef struct {
        logic g, rv, rdy;
        logic e_req; logic [31:0] e_addr;
        logic e_vld; logic [31:0] e_pc;
        logic [2:0] e_cnt;
    } vec_t;

    req_t pend[$];
    int   epoch = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are checked after #1.
    task automatic drive(input logic g, input logic rv, input logic rdy,
                         input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        assert (!(rv && pend.size() == 0)) else $error("rvalid requested with nothing outstanding");
        imem_gnt_i    = g;
        imem_rvalid_i = rv && (pend.size() != 0);
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_rdata_i  = imem_rvalid_i ? memf(pend[0].addr) : 32'hDEAD_BEEF;
        #1;
    endtask

    // Memory-side bookkeeping for the edge about to happen.
    task automatic commit();
        req_t tmp;
        if (imem_req_o && imem_gnt_i) pend.push_back('{imem_addr_o, epoch});
        if (imem_rvalid_i) tmp = pend.pop_front();
        if (redirect_i) epoch++;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0; imem_rdata_i = '0;
        pend.delete();
        #1;
        chk("rst_req",   32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc",    pc_o, RESET_PC);
        chk("rst_count", 32'(count_o), 32'd0);
        @(negedge clk);
        chk("rst_req_hold", 32'(imem_req_o), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_first_req",  32'(imem_req_o), 32'd1);
        chk("rst_first_addr", imem_addr_o, RESET_PC);
        @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [15];
        ent_t q[$];
        logic [31:0] fpc;
        reset = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0; imem_rdata_i = '0;

        //              g     rv    rdy   req   addr          vld   pc            cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 3'd1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h08, 3'd2};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 3'd2};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 3'd3};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 3'd4};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 3'd4};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 3'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h18, 3'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00, 3'd0};

        do_reset();

`ifndef IFQ_BYPASS_EN
        // Streaming, back-pressure to saturation and recovery.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].g, tbl[i].rv, tbl[i].rdy, 1'b0, 32'h0);
            chk($sformatf("t%0d_req", i), 32'(imem_req_o), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr_o, tbl[i].e_addr);
            chk($sformatf("t%0d_valid", i), 32'(instr_valid_o), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk($sformatf("t%0d_pc", i), pc_o, tbl[i].e_pc);
                chk($sformatf("t%0d_instr", i), instr_o, memf(tbl[i].e_pc));
            end
            chk($sformatf("t%0d_count", i), 32'(count_o), 32'(tbl[i].e_cnt));
            commit();
        end
`endif

        // Redirect with two requests outstanding.
        do_reset();
        drive(1, 0, 0, 0, 0); chk("rd1_addr0", imem_addr_o, 32'h0); commit();
        drive(1, 0, 0, 0, 0); chk("rd1_addr1", imem_addr_o, 32'h4); commit();
        drive(0, 0, 0, 1, 32'h100); chk("rd1_req_full", 32'(imem_req_o), 0); commit();
        drive(1, 1, 0, 0, 0);
        chk("rd1_drain_req0", 32'(imem_req_o), 0);
        chk("rd1_valid0", 32'(instr_valid_o), 0);
        chk("rd1_count0", 32'(count_o), 0);
        commit();
        drive(1, 1, 0, 0, 0); chk("rd1_drain_req1", 32'(imem_req_o), 0); commit();
        drive(1, 0, 0, 0, 0);
        chk("rd1_req_tgt", 32'(imem_req_o), 1);
        chk("rd1_addr_tgt", imem_addr_o, 32'h100);
        commit();
        drive(0, 1, 0, 0, 0); commit();
        drive(0, 0, 1, 0, 0);
        chk("rd1_out_valid", 32'(instr_valid_o), 1);
        chk("rd1_out_pc", pc_o, 32'h100);
        chk("rd1_out_instr", instr_o, memf(32'h100));
        commit();
        drive(0, 0, 0, 0, 0); chk("rd1_empty", 32'(instr_valid_o), 0); commit();

        // Redirect coinciding with grant, push and pop.
        do_reset();
        drive(1, 0, 0, 0, 0); commit();
        drive(1, 1, 0, 0, 0); commit();
        drive(1, 1, 1, 1, 32'h200);
        chk("rd2_pre_req", 32'(imem_req_o), 1);
        chk("rd2_pre_addr", imem_addr_o, 32'h8);
        chk("rd2_pre_pc", pc_o, 32'h0);
        commit();
        drive(0, 1, 1, 0, 0);
        chk("rd2_valid0", 32'(instr_valid_o), 0);
        chk("rd2_count0", 32'(count_o), 0);
        chk("rd2_drain_req", 32'(imem_req_o), 0);
        commit();
        drive(1, 0, 1, 0, 0);
        chk("rd2_req_tgt", 32'(imem_req_o), 1);
        chk("rd2_addr_tgt", imem_addr_o, 32'h200);
        chk("rd2_still_empty", 32'(instr_valid_o), 0);
        commit();
        drive(0, 1, 0, 0, 0); commit();
        drive(0, 0, 1, 0, 0);
        chk("rd2_out_valid", 32'(instr_valid_o), 1);
        chk("rd2_out_pc", pc_o, 32'h200);
        commit();

        // Fetch address wrap.
        do_reset();
        drive(0, 0, 0, 1, 32'hFFFF_FFFC); commit();
        drive(1, 0, 0, 0, 0); chk("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC); commit();
        drive(1, 1, 0, 0, 0); chk("wrap_addr_zero", imem_addr_o, 32'h0); commit();
        drive(0, 1, 1, 0, 0); chk("wrap_pc_top", pc_o, 32'hFFFF_FFFC); commit();
        drive(0, 0, 1, 0, 0);
        chk("wrap_pc_zero", pc_o, 32'h0);
        chk("wrap_instr_zero", instr_o, memf(32'h0));
        commit();

        // Response into an empty FIFO with consumer ready.
        do_reset();
        drive(1, 0, 1, 0, 0); commit();
        drive(0, 1, 1, 0, 0);
`ifdef IFQ_BYPASS_EN
        chk("lat_same_valid", 32'(instr_valid_o), 1);
        chk("lat_same_pc", pc_o, 32'h0);
        chk("lat_same_instr", instr_o, memf(32'h0));
        chk("lat_same_count", 32'(count_o), 0);
`else
        chk("lat_same_valid", 32'(instr_valid_o), 0);
        chk("lat_same_count", 32'(count_o), 0);
`endif
        commit();
        drive(0, 0, 1, 0, 0);
`ifdef IFQ_BYPASS_EN
        chk("lat_next_valid", 32'(instr_valid_o), 0);
        chk("lat_next_count", 32'(count_o), 0);
`else
        chk("lat_next_valid", 32'(instr_valid_o), 1);
        chk("lat_next_pc", pc_o, 32'h0);
        chk("lat_next_count", 32'(count_o), 1);
`endif
        commit();

        // Randomized run against the fetch-stream model.
        do_reset();
        q.delete();
        fpc = RESET_PC;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic g, rv, rdy, rd, fresh, stale, exp_req, byp;
            logic [31:0] rpc;
            g   = ($urandom % 10) < 7;
            rdy = ($urandom % 10) < 6;
            rv  = (pend.size() > 0) && (($urandom % 10) < 6);
            rd  = ($urandom % 40) == 0;
            rpc = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            drive(g, rv, rdy, rd, rpc);

            fresh = 1'b0;
            if (imem_rvalid_i) fresh = (pend[0].epoch == epoch);
            stale = 1'b0;
            foreach (pend[k]) if (pend[k].epoch != epoch) stale = 1'b1;
            exp_req = !stale && (q.size() + pend.size() < DEPTH) && (pend.size() < MAXO);
            byp = 1'b0;
`ifdef IFQ_BYPASS_EN
            byp = fresh && (q.size() == 0) && !rd;
`endif
            chk("rnd_req", 32'(imem_req_o), 32'(exp_req));
            if (exp_req) chk("rnd_addr", imem_addr_o, fpc);
            chk("rnd_count", 32'(count_o), 32'(q.size()));
            if (byp) begin
                chk("rnd_byp_valid", 32'(instr_valid_o), 1);
                chk("rnd_byp_pc", pc_o, pend[0].addr);
                chk("rnd_byp_instr", instr_o, memf(pend[0].addr));
            end else begin
                chk("rnd_valid", 32'(instr_valid_o), 32'(q.size() > 0));
                if (q.size() > 0) begin
                    chk("rnd_pc", pc_o, q[0].pc);
                    chk("rnd_instr", instr_o, q[0].ins);
                end
            end

            if (rd) begin
                q.delete();
                fpc = rpc;
            end else begin
                if (q.size() > 0 && rdy) void'(q.pop_front());
                if (fresh && !(byp && rdy)) q.push_back('{pend[0].addr, memf(pend[0].addr)});
                if (exp_req && g) fpc = fpc + 32'd4;
            end
            commit();
        end

        // Reset in the middle of traffic.
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
